// File: rtl/mpu_matrix_streamer_if.sv
// Load/stream bus between a matrix producer and the MPU result streamer.
// master = side that supplies matrices and consumes elements; slave = streamer.
interface mpu_matrix_streamer_if #(
    parameter int ELEM_W = 8,
    parameter int DIM    = 5
);
    logic                       load_valid;
    logic                       load_ready;
    logic [ELEM_W*DIM*DIM-1:0]  matrix_in;
    logic                       out_valid;
    logic                       out_ready;
    logic [ELEM_W-1:0]          out_data;
    logic [2:0]                 out_row;
    logic [2:0]                 out_col;
    logic                       out_last;
    logic                       busy;

    modport master (
        output load_valid, matrix_in, out_ready,
        input  load_ready, out_valid, out_data, out_row, out_col, out_last, busy
    );

    modport slave (
        input  load_valid, matrix_in, out_ready,
        output load_ready, out_valid, out_data, out_row, out_col, out_last, busy
    );
endinterface

// File: rtl/mpu_matrix_streamer.sv
// Captures one flattened DIM x DIM matrix and emits it one element per handshake.
// Define MPU_STREAM_COLMAJOR_EN for column-major emission order (default row-major).
module mpu_matrix_streamer #(
    parameter int ELEM_W = 8,
    parameter int DIM    = 5
) (
    input logic                   clk,
    input logic                   rst,
    mpu_matrix_streamer_if.slave  bus
);
    localparam int         MAT_W = ELEM_W * DIM * DIM;
    localparam int         IW    = $clog2(MAT_W);
    localparam logic [2:0] LAST  = 3'(DIM - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t           state, state_nxt;
    logic [MAT_W-1:0] mat;
    logic [2:0]       row, col, row_nxt, col_nxt;
    logic             load_fire;
    logic             at_last;
    logic [IW-1:0]    bit_base;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            mat   <= '0;
            row   <= '0;
            col   <= '0;
        end else begin
            state <= state_nxt;
            row   <= row_nxt;
            col   <= col_nxt;
            if (load_fire)
                mat <= bus.matrix_in;
        end
    end

    assign at_last = (row == LAST) && (col == LAST);

    always_comb begin
        state_nxt      = state;
        row_nxt        = row;
        col_nxt        = col;
        load_fire      = 1'b0;
        bus.load_ready = 1'b0;
        bus.out_valid  = 1'b0;
        bus.busy       = 1'b0;
        case (state)
            IDLE: begin
                bus.load_ready = 1'b1;
                if (bus.load_valid) begin
                    load_fire = 1'b1;
                    state_nxt = STREAM;
                    row_nxt   = '0;
                    col_nxt   = '0;
                end
            end
            STREAM: begin
                bus.out_valid = 1'b1;
                bus.busy      = 1'b1;
                if (bus.out_ready) begin
                    if (at_last) begin
                        // Counters park at (0,0) so the idle outputs match reset.
                        state_nxt = IDLE;
                        row_nxt   = '0;
                        col_nxt   = '0;
`ifdef MPU_STREAM_COLMAJOR_EN
                    end else if (row == LAST) begin
                        row_nxt = '0;
                        col_nxt = col + 3'd1;
                    end else begin
                        row_nxt = row + 3'd1;
                    end
`else
                    end else if (col == LAST) begin
                        col_nxt = '0;
                        row_nxt = row + 3'd1;
                    end else begin
                        col_nxt = col + 3'd1;
                    end
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Element (i,j) lives at flat index i + DIM*j.
    assign bit_base     = IW'(ELEM_W * (int'(row) + DIM * int'(col)));
    assign bus.out_data = mat[bit_base +: ELEM_W];
    assign bus.out_row  = row;
    assign bus.out_col  = col;
    assign bus.out_last = (state == STREAM) && at_last;
endmodule

// File: tb/tb_mpu_matrix_streamer.sv
// Directed bench for mpu_matrix_streamer: table of expected elements plus
// hand-written sequences for backpressure, isolation, reset and back-to-back loads.
module tb_mpu_matrix_streamer;
    localparam int ELEM_W = 8;
    localparam int DIM    = 5;
    localparam int N      = DIM * DIM;

    typedef struct {
        logic [2:0] row;
        logic [2:0] col;
        logic [7:0] data;
        logic       last;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    vec_t tbl [N];
    logic [7:0] got_data [N];
    logic [ELEM_W*N-1:0] m_seq;
    int   cy;

    mpu_matrix_streamer_if #(.ELEM_W(ELEM_W), .DIM(DIM)) bus ();

    mpu_matrix_streamer #(.ELEM_W(ELEM_W), .DIM(DIM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_out_valid"},  32'(bus.out_valid), 0);
        check({tag, "_load_ready"}, 32'(bus.load_ready), 1);
        check({tag, "_busy"},       32'(bus.busy), 0);
        check({tag, "_out_row"},    32'(bus.out_row), 0);
        check({tag, "_out_col"},    32'(bus.out_col), 0);
        check({tag, "_out_last"},   32'(bus.out_last), 0);
    endtask

    // Called just after a rising edge; presents a matrix for one handshake.
    task automatic do_load(input logic [ELEM_W*N-1:0] m, input bit keep);
        bus.matrix_in  = m;
        bus.load_valid = 1'b1;
        @(negedge clk);
        check("load_ready_idle", 32'(bus.load_ready), 1);
        @(posedge clk);
        #1;
        if (!keep) bus.load_valid = 1'b0;
    endtask

    // mode 0: out_ready always 1; mode 1: out_ready pattern 1,0,0 repeating.
    task automatic run_stream(input int mode, input int stop_n, input bit flood,
                              input bit sevens, output int cycles);
        int n, cyc;
        bit stall;
        logic [7:0] sd;
        logic [2:0] sr, sc;
        logic sl;
        n = 0; cyc = 0; stall = 0;
        sd = '0; sr = '0; sc = '0; sl = 1'b0;
        while (n < stop_n && cyc < 300) begin
            bus.out_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
            if (flood) begin
                bus.load_valid = 1'b1;
                bus.matrix_in  = {N{8'hFF}};
            end
            @(negedge clk);
            check("stream_out_valid", 32'(bus.out_valid), 1);
            check("stream_busy", 32'(bus.busy), 1);
            if (flood) check("iso_load_ready", 32'(bus.load_ready), 0);
            if (stall) begin
                check("stall_data", 32'(bus.out_data), 32'(sd));
                check("stall_row",  32'(bus.out_row),  32'(sr));
                check("stall_col",  32'(bus.out_col),  32'(sc));
                check("stall_last", 32'(bus.out_last), 32'(sl));
            end
            stall = 0;
            if (bus.out_valid && bus.out_ready) begin
                check("elem_row",  32'(bus.out_row),  32'(tbl[n].row));
                check("elem_col",  32'(bus.out_col),  32'(tbl[n].col));
                check("elem_data", 32'(bus.out_data), sevens ? 32'd7 : 32'(tbl[n].data));
                check("elem_last", 32'(bus.out_last), 32'(tbl[n].last));
                got_data[n] = bus.out_data;
                n++;
            end else if (bus.out_valid) begin
                sd = bus.out_data; sr = bus.out_row; sc = bus.out_col; sl = bus.out_last;
                stall = 1;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.out_ready = 1'b0;
        check("xfer_count", 32'(n), 32'(stop_n));
        cycles = cyc;
    endtask

    initial begin
        int r, c;
        bus.load_valid = 1'b0;
        bus.out_ready  = 1'b0;
        bus.matrix_in  = '0;

        for (int k = 0; k < N; k++) begin
`ifdef MPU_STREAM_COLMAJOR_EN
            r = k % DIM; c = k / DIM;
`else
            r = k / DIM; c = k % DIM;
`endif
            tbl[k].row  = 3'(r);
            tbl[k].col  = 3'(c);
            tbl[k].data = 8'(N - (r + DIM * c));
            tbl[k].last = (k == N - 1);
        end
        // {8'd1, ..., 8'd25} with the first value in the top byte.
        for (int k = 0; k < N; k++) m_seq[8*k +: 8] = 8'(N - k);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        check("reset_out_data", 32'(bus.out_data), 0);
        rst = 1'b0;

        // Reset and load_valid together: reset wins, nothing captured
        rst = 1'b1; bus.load_valid = 1'b1; bus.matrix_in = m_seq;
        @(posedge clk);
        #1;
        rst = 1'b0; bus.load_valid = 1'b0;
        check_idle("rst_vs_load");
        check("rst_vs_load_data", 32'(bus.out_data), 0);

        // Full stream with out_ready held high
        do_load(m_seq, 0);
        run_stream(0, N, 0, 0, cy);
        check("cont_cycles", 32'(cy), N);
        check("cont_end_load_ready", 32'(bus.load_ready), 1);
        check("cont_end_busy", 32'(bus.busy), 0);
`ifdef MPU_STREAM_COLMAJOR_EN
        check("cm_d0", 32'(got_data[0]), 25);
        check("cm_d1", 32'(got_data[1]), 24);
        check("cm_d2", 32'(got_data[2]), 23);
        check("cm_d3", 32'(got_data[3]), 22);
        check("cm_d4", 32'(got_data[4]), 21);
`else
        check("row0_d0", 32'(got_data[0]), 25);
        check("row0_d1", 32'(got_data[1]), 20);
        check("row0_d2", 32'(got_data[2]), 15);
        check("row0_d3", 32'(got_data[3]), 10);
        check("row0_d4", 32'(got_data[4]), 5);
        check("row1_d0", 32'(got_data[5]), 24);
        check("row1_d4", 32'(got_data[9]), 4);
`endif
        check("final_data", 32'(got_data[N-1]), 1);

        // Backpressure
        do_load(m_seq, 0);
        run_stream(1, N, 0, 0, cy);
        check("bp_end_busy", 32'(bus.busy), 0);
        check("bp_end_out_valid", 32'(bus.out_valid), 0);

        // Load isolation
        do_load(m_seq, 0);
        run_stream(0, N, 1, 0, cy);
        bus.load_valid = 1'b0;
        check("iso_end_load_ready", 32'(bus.load_ready), 1);
        check("iso_end_out_valid", 32'(bus.out_valid), 0);

        // Reset mid-stream after the 7th transfer
        do_load(m_seq, 0);
        run_stream(0, 7, 0, 0, cy);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_idle("mid_rst");
        check("mid_rst_data", 32'(bus.out_data), 0);
        do_load(m_seq, 0);
        run_stream(0, N, 0, 0, cy);

        // Back-to-back loads with load_valid held high
        do_load(m_seq, 1);
        bus.matrix_in = {N{8'd7}};
        run_stream(0, N, 0, 0, cy);
        check("b2b_bubble_valid", 32'(bus.out_valid), 0);
        check("b2b_bubble_load_ready", 32'(bus.load_ready), 1);
        @(posedge clk);
        #1;
        bus.load_valid = 1'b0;
        run_stream(0, N, 0, 1, cy);
        check("b2b_second_cycles", 32'(cy), N);
        check("b2b_end_load_ready", 32'(bus.load_ready), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mpu_matrix_streamer.md
Name: mpu_matrix_streamer

Overview:
Output-side serializer for the MPU. It captures one flattened DIM x DIM matrix, such as the result bus of the matrix adder, in a single load handshake. It then emits the matrix one element per valid/ready handshake, tagged with row, column and last indications. It sits between the MPU arithmetic blocks and the byte-wide result/readback path.

Parameters:
ELEM_W, 8, bits per matrix element
DIM, 5, matrix dimension (rows = columns = DIM; DIM <= 7 so indices fit 3 bits)

Ports:
clk  input  1  system clock; all state changes on its rising edge
rst  input  1  synchronous, active-high reset
load_valid  input  1  matrix_in holds a matrix to capture
load_ready  output  1  streamer can accept a matrix
matrix_in  input  ELEM_W*DIM*DIM  flattened matrix; element (row i, col j) at bits [ELEM_W*(i+DIM*j) +: ELEM_W]
out_valid  output  1  out_data/out_row/out_col/out_last are valid
out_ready  input  1  downstream accepts current element
out_data  output  ELEM_W  current element value
out_row  output  3  row index of current element
out_col  output  3  column index of current element
out_last  output  1  current element is the final one of the matrix
busy  output  1  high while a matrix is held (state STREAM)

Behaviour:
- Reset: clk and rst are the only clock and reset. Reset is synchronous and active-high, applied on the rising edge of clk while rst=1.
- Reset values: state=IDLE, load_ready=1, out_valid=0, out_data=0, out_row=0, out_col=0, out_last=0, busy=0, matrix register=0.
- FSM states:
  - IDLE: load_ready=1, out_valid=0.
  - STREAM: load_ready=0, out_valid=1, busy=1.
- IDLE -> STREAM: on a cycle with load_valid && load_ready.
  - matrix_in is captured into the internal register; the row and column counters are set to 0.
  - Latency: out_valid rises the cycle after the load handshake, presenting element (0,0).
- Handshake: an element transfers on a cycle with out_valid && out_ready.
  - While out_valid=1 and out_ready=0, all out_* signals hold stable.
  - out_valid never drops before the transfer completes.
- Order (default): row-major. The column counter increments first. On col==DIM-1 it wraps to 0 and the row counter increments.
- out_last=1 exactly when the presented element is (DIM-1, DIM-1).
  - Transfer of that element returns the FSM to IDLE.
  - load_ready returns high on the following cycle, leaving one bubble cycle between matrices.
  - Exactly DIM*DIM transfers occur per load.
- out_data, out_row and out_col are combinational selects from the held matrix and counters. No extra pipeline register is used.
- Input isolation: changes on matrix_in during STREAM have no effect. load_valid during STREAM is ignored and is not queued.
- Reset mid-stream: rst=1 in any cycle aborts the matrix. The next cycle shows the reset values, and the remaining elements are discarded.
- Simultaneous rst and load_valid: reset wins and no capture occurs.
- out_ready held high: one element per cycle, so DIM*DIM consecutive cycles with out_valid=1.
- Counter widths are 3 bits. No out-of-range index (>= DIM) is ever presented.

Optional Feature:
- Macro: MPU_STREAM_COLMAJOR_EN.
- When defined: emission order is column-major.
  - The row counter increments first; on row==DIM-1 it wraps to 0 and the column counter increments.
  - out_row and out_col still report the true indices of each element.
  - out_last still marks (DIM-1, DIM-1), and the total count is still DIM*DIM.
- When undefined: row-major order as described above; no column-major logic is present.

Test Plan:
- Test vectors: matrix_in = {8'd1,8'd2,...,8'd25}, MSB first, so bits [7:0]=25.
  - Load, then out_ready=1 constantly.
  - Expect 25 consecutive transfers starting the cycle after the load.
  - Row 0 data: 25,20,15,10,5. Row 1 data: 24,19,14,9,4.
  - The final transfer is (4,4) with data=1 and out_last=1. out_last=1 on no other transfer.
- Backpressure: same load with out_ready toggling 1,0,0,1,...
  - out_* are stable during every stall cycle.
  - The element sequence is identical to the first test.
  - busy falls only after the transfer with out_last=1.
- Load isolation: during STREAM, drive matrix_in={25{8'hFF}} with load_valid=1.
  - Output continues to emit the original values.
  - load_ready=0 throughout the stream.
  - load_ready=1 in the cycle after the last transfer.
- Reset mid-stream: assert rst for 1 cycle after the 7th transfer.
  - Next cycle: out_valid=0, load_ready=1, busy=0, out_row=out_col=0.
  - A new load then restarts at (0,0).
- Back-to-back: hold load_valid=1 with matrix_in={1..25}, then switch matrix_in to {25{8'd7}} after the first capture.
  - Exactly one idle cycle separates the two matrices.
  - The second matrix emits 25 transfers, all with data 7.
- With MPU_STREAM_COLMAJOR_EN defined, load {1..25} again.
  - First five transfers: data 25,24,23,22,21 with rows 0..4 and col 0.
  - Last transfer: data=1 at (4,4) with out_last=1.
